// File: rtl/card_dealer_seq.sv
// card_dealer_seq
// Arbitrates the shared RNG card source between the initial four-card deal,
// dealer draws and player hits, while tracking a finite shoe so that
// exhausted ranks are never dealt. Each dealt card is tagged with its
// destination hand and slot index.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   rng_value             free-running RNG sample, consumed in DRAW
//   deal_start, shuffle   one-cycle command pulses
//   p_req, d_req          level requests held until the matching ack
//   p_ack, d_ack          one-cycle grants, coincident with card_valid
//   card_valid            strobe: card_rank/card_dest/card_slot valid
//   card_rank/dest/slot   last dealt card (held between strobes)
//   init_done             pulses with the 4th card of the initial deal
//   deal_error            pulses when a draw finds the shoe empty
//   busy                  FSM is not in IDLE
//   shoe_empty, cards_left  shoe status
//
// state  | meaning
// IDLE   | arbitrate: pending shuffle > deal_start > d_req > p_req
// DRAW   | sample rng_value until an available rank is accepted/forced
// EMIT   | present the registered card, ack the requester if any
// REFILL | reload every rank counter and cards_left
module card_dealer_seq #(
  parameter int NUM_DECKS = 1,
  parameter int MAX_RETRY = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rng_value,
  input  logic       deal_start,
  input  logic       shuffle,
  input  logic       p_req,
  input  logic       d_req,
  output logic       p_ack,
  output logic       d_ack,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic       card_dest,
  output logic [2:0] card_slot,
  output logic       init_done,
  output logic       deal_error,
  output logic       busy,
  output logic       shoe_empty,
  output logic [8:0] cards_left
);

  localparam int              RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [5:0]      RANK_FULL = 6'(4 * NUM_DECKS);
  localparam logic [8:0]      SHOE_FULL = 9'(52 * NUM_DECKS);
  localparam logic [RW-1:0]   RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, DRAW, EMIT, REFILL} state_t;
  typedef enum logic [1:0] {SRC_INIT, SRC_P, SRC_D} src_t;

  state_t        state, state_nxt;
  src_t          src;
  // Entries 0, 14 and 15 stay zero so any raw rng_value can index directly.
  logic [5:0]    cnt [0:15];
  logic          pend_shuffle;
  logic          req_block;
  logic [1:0]    init_step;
  logic [2:0]    p_slot, d_slot;
  logic [RW-1:0] retry;
  logic [3:0]    low_rank, pick_rank;
  logic          rng_ok, take, pick_dest;

  assign shoe_empty = (cards_left == 9'd0);
  assign busy       = (state != IDLE);
  assign rng_ok     = (cnt[rng_value] != 6'd0);
  assign take       = !shoe_empty && (rng_ok || (retry == RETRY_MAX));
  assign pick_rank  = rng_ok ? rng_value : low_rank;
  assign pick_dest  = (src == SRC_INIT) ? init_step[0] : (src == SRC_D);

  always_comb begin
    low_rank = 4'd1;
    for (int i = 13; i >= 1; i--)
      if (cnt[i] != 6'd0) low_rank = 4'(i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    p_ack      = 1'b0;
    d_ack      = 1'b0;
    card_valid = 1'b0;
    init_done  = 1'b0;
    deal_error = 1'b0;
    case (state)
      IDLE: begin
        if (pend_shuffle || shuffle)
          state_nxt = REFILL;
        else if (deal_start || ((d_req || p_req) && !req_block))
          state_nxt = DRAW;
      end
      DRAW: begin
        if (shoe_empty) begin
          deal_error = 1'b1;
          state_nxt  = IDLE;
        end else if (take) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        card_valid = 1'b1;
        p_ack      = (src == SRC_P);
        d_ack      = (src == SRC_D);
        if (src == SRC_INIT && init_step != 2'd3) begin
          state_nxt = DRAW;
        end else begin
          init_done = (src == SRC_INIT);
          state_nxt = IDLE;
        end
      end
      REFILL:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++)
        cnt[i] <= (i >= 1 && i <= 13) ? RANK_FULL : 6'd0;
      cards_left   <= SHOE_FULL;
      pend_shuffle <= 1'b0;
      req_block    <= 1'b0;
      init_step    <= 2'd0;
      p_slot       <= 3'd0;
      d_slot       <= 3'd0;
      retry        <= '0;
      src          <= SRC_INIT;
      card_rank    <= 4'd0;
      card_dest    <= 1'b0;
      card_slot    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          retry <= '0;
          if (!(pend_shuffle || shuffle)) begin
            if (deal_start) begin
              src       <= SRC_INIT;
              init_step <= 2'd0;
              p_slot    <= 3'd0;
              d_slot    <= 3'd0;
            end else if (d_req && !req_block) begin
              src <= SRC_D;
            end else if (p_req && !req_block) begin
              src <= SRC_P;
            end
          end
        end
        DRAW: begin
          if (shoe_empty) begin
            // Hold off requests until a refill so an empty shoe reports once.
            req_block <= 1'b1;
          end else if (take) begin
            cnt[pick_rank] <= cnt[pick_rank] - 6'd1;
            cards_left     <= cards_left - 9'd1;
            card_rank      <= pick_rank;
            card_dest      <= pick_dest;
            retry          <= '0;
            if (pick_dest) begin
              card_slot <= d_slot;
              if (d_slot != 3'd7) d_slot <= d_slot + 3'd1;
            end else begin
              card_slot <= p_slot;
              if (p_slot != 3'd7) p_slot <= p_slot + 3'd1;
            end
          end else begin
            retry <= retry + 1'b1;
          end
        end
        EMIT: begin
          retry <= '0;
          if (src == SRC_INIT) init_step <= init_step + 2'd1;
        end
        REFILL: begin
          for (int i = 0; i < 16; i++)
            cnt[i] <= (i >= 1 && i <= 13) ? RANK_FULL : 6'd0;
          cards_left   <= SHOE_FULL;
          pend_shuffle <= 1'b0;
          req_block    <= 1'b0;
        end
        default: ;
      endcase
      // A shuffle seen outside IDLE is remembered; written last so a pulse
      // arriving during REFILL itself is not lost.
      if (state != IDLE && shuffle) pend_shuffle <= 1'b1;
    end
  end

endmodule

// File: tb/tb_card_dealer_seq.sv
module tb_card_dealer_seq;
  localparam int NUM_DECKS = 1;
  localparam int MAX_RETRY = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rng_value;
  logic       deal_start, shuffle, p_req, d_req;
  logic       p_ack, d_ack, card_valid, card_dest, init_done, deal_error, busy, shoe_empty;
  logic [3:0] card_rank;
  logic [2:0] card_slot;
  logic [8:0] cards_left;

  card_dealer_seq #(.NUM_DECKS(NUM_DECKS), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .reset(reset), .rng_value(rng_value), .deal_start(deal_start),
    .shuffle(shuffle), .p_req(p_req), .d_req(d_req), .p_ack(p_ack), .d_ack(d_ack),
    .card_valid(card_valid), .card_rank(card_rank), .card_dest(card_dest),
    .card_slot(card_slot), .init_done(init_done), .deal_error(deal_error),
    .busy(busy), .shoe_empty(shoe_empty), .cards_left(cards_left)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference shoe: copies left per rank, total, and next slot per hand.
  int mcnt [1:13];
  int mleft, mp_slot, md_slot;
  int last_rank, last_dest, last_slot;

  task automatic model_fill();
    for (int i = 1; i <= 13; i++) mcnt[i] = 4 * NUM_DECKS;
    mleft = 52 * NUM_DECKS;
  endtask

  function automatic bit rank_ok(input int v);
    if (v < 1 || v > 13) return 1'b0;
    return mcnt[v] > 0;
  endfunction

  function automatic int lowest_rank();
    int r = 0;
    for (int i = 13; i >= 1; i--) if (mcnt[i] > 0) r = i;
    return r;
  endfunction

  // Entered at the negedge of the cycle before the FSM enters DRAW.
  // Drives one RNG sample per DRAW cycle and returns at the negedge of the
  // cycle that should carry the card.
  task automatic draw_window(input bit dest, input bit is_req, input bit last_init,
                             input int fixed, input bit pulse_shuf);
    int list [0:MAX_RETRY];
    int exp_i, exp_rank, exp_slot, c;
    bit found;
    for (int k = 0; k <= MAX_RETRY; k++)
      list[k] = (fixed >= 0) ? fixed : int'($urandom_range(15, 0));
    exp_i = -1;
    for (int k = 0; k < MAX_RETRY; k++)
      if (exp_i < 0 && rank_ok(list[k])) exp_i = k;
    if (exp_i >= 0) exp_rank = list[exp_i];
    else begin
      exp_i    = MAX_RETRY;
      exp_rank = rank_ok(list[MAX_RETRY]) ? list[MAX_RETRY] : lowest_rank();
    end
    exp_slot = dest ? md_slot : mp_slot;
    found = 1'b0;
    c = 0;
    while (!found && c < MAX_RETRY + 6) begin
      @(negedge clk);
      c++;
      if (card_valid) found = 1'b1;
      else if (c - 1 <= MAX_RETRY) rng_value = 4'(list[c - 1]);
      else rng_value = 4'd0;
      deal_start = 1'b0;
      shuffle    = pulse_shuf && (c == 1);
    end
    checks++;
    if (!found || c != exp_i + 2) begin
      errors++;
      $display("FAIL latency dest=%0d got=%0d cycles (found=%0d) expected=%0d", dest, c, found, exp_i + 2);
    end
    if (found) begin
      mcnt[exp_rank]--;
      mleft--;
      checks++;
      if ({card_rank, card_dest, card_slot, cards_left, shoe_empty} !==
          {4'(exp_rank), dest, 3'(exp_slot), 9'(mleft), (mleft == 0)}) begin
        errors++;
        $display("FAIL card got rank=%0d dest=%0d slot=%0d left=%0d empty=%0d expected rank=%0d dest=%0d slot=%0d left=%0d",
                 card_rank, card_dest, card_slot, cards_left, shoe_empty, exp_rank, dest, exp_slot, mleft, mleft == 0);
      end
      checks++;
      if ({p_ack, d_ack, init_done, deal_error} !== {is_req && !dest, is_req && dest, last_init, 1'b0}) begin
        errors++;
        $display("FAIL strobes got p_ack=%0d d_ack=%0d init_done=%0d deal_error=%0d expected %0d %0d %0d 0",
                 p_ack, d_ack, init_done, deal_error, is_req && !dest, is_req && dest, last_init);
      end
      if (dest) begin if (md_slot < 7) md_slot++; end
      else begin if (mp_slot < 7) mp_slot++; end
      last_rank = exp_rank; last_dest = dest; last_slot = exp_slot;
    end
  endtask

  task automatic check_hold();
    checks++;
    if ({busy, card_valid, card_rank, card_dest, card_slot} !==
        {1'b0, 1'b0, 4'(last_rank), 1'(last_dest), 3'(last_slot)}) begin
      errors++;
      $display("FAIL hold_idle got busy=%0d valid=%0d rank=%0d dest=%0d slot=%0d expected 0 0 %0d %0d %0d",
               busy, card_valid, card_rank, card_dest, card_slot, last_rank, last_dest, last_slot);
    end
  endtask

  task automatic do_req(input bit dealer, input int fixed);
    @(negedge clk);
    check_hold();
    if (dealer) d_req = 1'b1; else p_req = 1'b1;
    draw_window(dealer, 1'b1, 1'b0, fixed, 1'b0);
    d_req = 1'b0;
    p_req = 1'b0;
  endtask

  task automatic do_deal(input int fixed, input int shuf_step);
    @(negedge clk);
    check_hold();
    deal_start = 1'b1;
    mp_slot = 0;
    md_slot = 0;
    for (int s = 0; s < 4; s++)
      draw_window((s % 2) == 1, 1'b0, s == 3, fixed, s == shuf_step);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rng_value = 4'd0; deal_start = 1'b0; shuffle = 1'b0; p_req = 1'b0; d_req = 1'b0;
    model_fill(); mp_slot = 0; md_slot = 0;
    last_rank = 0; last_dest = 0; last_slot = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({p_ack, d_ack, card_valid, card_rank, card_dest, card_slot, init_done, deal_error, busy, shoe_empty, cards_left} !==
        {11'd0, 1'b0, 3'd0, 4'd0, 9'(52 * NUM_DECKS)}) begin
      errors++;
      $display("FAIL reset_values got valid=%0d rank=%0d busy=%0d left=%0d expected 0 0 0 %0d",
               card_valid, card_rank, busy, cards_left, 52 * NUM_DECKS);
    end
    reset = 1'b0;
  endtask

  task automatic test_dual_req();
    @(negedge clk);
    check_hold();
    d_req = 1'b1;
    p_req = 1'b1;
    draw_window(1'b1, 1'b1, 1'b0, 9, 1'b0);
    d_req = 1'b0;
    @(negedge clk);
    draw_window(1'b0, 1'b1, 1'b0, 9, 1'b0);
    p_req = 1'b0;
  endtask

  task automatic test_shuffle_mid_deal();
    do_deal(-1, 1);
    @(negedge clk);
    checks++;
    if ({busy, cards_left} !== {1'b0, 9'(mleft)}) begin
      errors++;
      $display("FAIL shuf_idle got busy=%0d left=%0d expected 0 %0d", busy, cards_left, mleft);
    end
    @(negedge clk);
    checks++;
    if ({busy, cards_left} !== {1'b1, 9'(mleft)}) begin
      errors++;
      $display("FAIL shuf_refill got busy=%0d left=%0d expected 1 %0d", busy, cards_left, mleft);
    end
    @(negedge clk);
    model_fill();
    checks++;
    if ({busy, cards_left, shoe_empty} !== {1'b0, 9'(mleft), 1'b0}) begin
      errors++;
      $display("FAIL shuf_done got busy=%0d left=%0d expected 0 %0d", busy, cards_left, mleft);
    end
  endtask

  task automatic test_drain_empty();
    int errs_seen;
    while (mleft > 0) do_req(1'($urandom_range(1, 0)), -1);
    @(negedge clk);
    p_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({deal_error, p_ack, card_valid, shoe_empty} !== 4'b1001) begin
      errors++;
      $display("FAIL empty_draw got err=%0d p_ack=%0d valid=%0d empty=%0d expected 1 0 0 1",
               deal_error, p_ack, card_valid, shoe_empty);
    end
    errs_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (deal_error || card_valid || p_ack) errs_seen++;
    end
    checks++;
    if (errs_seen !== 0) begin
      errors++;
      $display("FAIL empty_quiet got %0d strobe cycles expected 0", errs_seen);
    end
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL empty_refill got busy=%0d expected 1", busy);
    end
    @(negedge clk);
    model_fill();
    checks++;
    if ({cards_left, shoe_empty} !== {9'(mleft), 1'b0}) begin
      errors++;
      $display("FAIL refilled got left=%0d empty=%0d expected %0d 0", cards_left, shoe_empty, mleft);
    end
    draw_window(1'b0, 1'b1, 1'b0, -1, 1'b0);
    p_req = 1'b0;
  endtask

  task automatic test_reset_mid_draw();
    @(negedge clk);
    p_req = 1'b1;
    rng_value = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_draw_busy got %0d expected 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({p_ack, d_ack, card_valid, card_rank, card_dest, card_slot, init_done, deal_error, busy, shoe_empty, cards_left} !==
        {11'd0, 1'b0, 3'd0, 4'd0, 9'(52 * NUM_DECKS)}) begin
      errors++;
      $display("FAIL async_reset got rank=%0d slot=%0d busy=%0d left=%0d expected 0 0 0 %0d",
               card_rank, card_slot, busy, cards_left, 52 * NUM_DECKS);
    end
    p_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_fill(); mp_slot = 0; md_slot = 0;
    last_rank = 0; last_dest = 0; last_slot = 0;
    do_req(1'b1, -1);
  endtask

  initial begin
    test_reset();
    do_deal(5, -1);          // test_deal_fixed
    test_dual_req();
    do_req(1'b0, 0);         // test_forced: all-zero RNG
    do_deal(13, -1);         // test_exhaust: drain rank 13 ...
    do_req(1'b1, 13);        // ... then a forced pick instead of 13
    repeat (3) do_req(1'($urandom_range(1, 0)), 13);
    test_shuffle_mid_deal();
    repeat (6) do_req(1'($urandom_range(1, 0)), -1);
    do_deal(-1, -1);
    repeat (4) do_req(1'($urandom_range(1, 0)), -1);
    test_drain_empty();
    test_reset_mid_draw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/card_dealer_seq.md
# card_dealer_seq

Sequences and arbitrates the single shared card source (the free-running RNG) between the player-hit and dealer-draw requesters and the four-card initial deal. It tracks a finite shoe so exhausted ranks are never dealt. It tags every dealt card with destination and hand slot for the game FSM and the VGA renderer. It sits between the RNG and the blackjack FSM/VGA blocks, inside the blackjack top level.

## Interface
- NUM_DECKS, default 1: decks in the shoe, 1..8. Each rank starts at 4*NUM_DECKS copies.
- MAX_RETRY, default 15: consecutive rejected RNG samples before the forced pick.
- clk  in  1  system clock (CLOCK_50 domain); one clock only.
- reset  in  1  reset, asynchronous, active-high.
- rng_value  in  4  free-running RNG output, sampled in DRAW.
- deal_start  in  1  one-cycle pulse that starts the initial deal.
- shuffle  in  1  one-cycle pulse that refills the shoe.
- p_req  in  1  player card request; held level until p_ack.
- d_req  in  1  dealer card request; held level until d_ack.
- p_ack / d_ack  out  1  one-cycle grant, coincident with the card's card_valid.
- card_valid  out  1  one-cycle strobe; card_rank, card_dest and card_slot are valid.
- card_rank  out  4  dealt rank, 1..13.
- card_dest  out  1  0 = player, 1 = dealer.
- card_slot  out  3  index of the card in its hand; saturates at 7.
- init_done  out  1  pulse with the 4th initial card.
- deal_error  out  1  pulse when a draw is attempted on an empty shoe.
- busy  out  1  high in any state except IDLE.
- shoe_empty  out  1  high when cards_left == 0.
- cards_left  out  9  cards remaining in the shoe.

## Operation
- Shoe storage: 13 per-rank counters of 6 bits each, plus cards_left.
- On reset or shuffle, every rank counter is set to 4*NUM_DECKS and cards_left to 52*NUM_DECKS.
- States: IDLE, DRAW, EMIT, REFILL.
- IDLE arbitration priority, from highest: pending shuffle, then deal_start, then d_req, then p_req.
- shuffle while busy is latched into a pending flag and serviced on the next IDLE.
- deal_start while busy is ignored.
- REFILL: one cycle to reload the counters, then return to IDLE.
- deal_start: clears both slot counters and sets init_step = 0. The deal order is player slot 0, dealer slot 0, player slot 1, dealer slot 1.
- DRAW acceptance: sample rng_value each cycle. Accept when 1 ≤ rng_value ≤ 13 and count[rng_value] > 0.
- DRAW rejection: otherwise increment the retry counter.
- Forced pick: when the retry counter reaches MAX_RETRY, take the lowest rank with a nonzero count.
- On accept: decrement count[rank] and cards_left, register the card, go to EMIT.
- EMIT: drive card_valid, plus the matching ack when the draw served a request.
- Slot handling: card_slot takes the destination's slot counter, which then increments and saturates at 7.
- After an EMIT during the initial deal: return to DRAW for the next step. After step 3, pulse init_done and go to IDLE.
- After an EMIT that served a request: go to IDLE.
- Empty shoe at entry to DRAW: pulse deal_error, issue no card and no ack, abort any initial-deal sequence (no init_done), and return to IDLE.
- Requests are not granted while shoe_empty. p_req and d_req stay pending until a shuffle.
- Reset mid-operation: the state machine returns to IDLE immediately and all outputs take their reset values.

## Timing
- Reset values: every output is 0 except cards_left = 52*NUM_DECKS. The shoe is full and the pending flag is clear.
- Request latency: a request seen in IDLE at cycle 0 enters DRAW at cycle 1. With acceptance there, card_valid and ack occur at cycle 2.
- Each rejection adds 1 cycle; worst-case request latency is 2 + MAX_RETRY.
- Initial deal: each card takes a minimum of 2 cycles. init_done is at cycle 8 after the deal_start cycle.
- A requester must deassert its request the cycle after its ack, otherwise it is treated as a new request.
- Simultaneous p_req and d_req: the dealer is served first and the player on the next IDLE.
- shoe_empty and cards_left update the cycle after the accepting DRAW cycle, together with card_valid.
- card_rank, card_dest and card_slot hold their values between strobes.

## Test plan
- Reset, then deal_start with rng_value held at 5. Required: cards 5/P/0, 5/D/0, 5/P/1, 5/D/1 on cycles 2, 4, 6, 8; init_done on cycle 8; cards_left = 48.
- d_req and p_req asserted in the same cycle, with rng = 9. Required: d_ack with 9/D at cycle 2, then p_ack with 9/P at cycle 5.
- rng held at 0 with MAX_RETRY = 15. Required: forced pick of rank 1 at cycle 17; count[1] decremented.
- Deal 4 cards of rank 13, then hold rng at 13. Required: forced pick of rank 1 after 15 rejections, and rank 13 never dealt again.
- Drain 52 cards, then assert p_req. Required: deal_error pulse, no p_ack, shoe_empty = 1. Then shuffle: cards_left = 52, and the pending p_req is served.
- Assert shuffle during the initial deal. Required: the deal completes and init_done pulses, then REFILL runs and cards_left = 52. Assert reset mid-DRAW: all outputs go to their reset values asynchronously.
